// File: rtl/cpu_pkg.sv
// Shared CPU-side types and widths for the fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int INST_W       = 32;
    localparam int PC_W         = 32;
    localparam int FETCH_ADDR_W = 5;   // default instruction-memory byte-address width

    // One prefetch queue entry: byte PC of the word plus the assembled word.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head entry is presented combinationally.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: a push while full is accepted only together with a pop; flush wins over push/pop.
//
// Ports: clk/rst_n; i_push/i_push_dat write the tail; i_pop advances the head;
// i_flush empties the queue; o_head_dat, o_count, o_full, o_empty report state.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_dat,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    // When full, the tail slot is the head slot; the head is read this cycle
    // and overwritten at the edge, so pop+push while full is safe.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch: reads byte-wide big-endian imem, assembles 32-bit words into a prefetch queue.
// Latency: 4 cycles from reset release or redirect to inst_valid; 1 word per 4 cycles steady state.
// Backpressure: byte fetch keeps running until the queue is full and byte 3 is pending, then holds.
//
// Ports: clk, rst_n (async active-low); imem_addr/imem_data byte read port;
// redirect/redirect_pc flush and restart; inst_valid/inst/inst_pc/inst_ready decode handshake.
module fetch_prefetch
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = FETCH_ADDR_W,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] r_fpc;
    logic [1:0]      r_bcnt;
    logic [23:0]     r_asm;

    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head_entry;
    logic [CNT_W-1:0] w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_word_done;
    logic            w_push_ok;
    logic            w_push;
    logic            w_unused;

    // Address depends only on fetch state, never on inst_ready or redirect.
    assign imem_addr = r_fpc[ADDR_W-1:0] + ADDR_W'(r_bcnt);

    assign w_pop       = inst_valid && inst_ready;
    assign w_word_done = (r_bcnt == 2'd3);
    assign w_push_ok   = !w_full || w_pop;
    // A word completing in the redirect cycle belongs to the old stream; drop it.
    assign w_push      = w_word_done && w_push_ok && !redirect;

    assign w_push_entry.pc   = r_fpc;
    assign w_push_entry.inst = {r_asm, imem_data};

    sync_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_entry),
        .i_pop      (w_pop),
        .i_flush    (redirect),
        .o_head_dat (w_head_entry),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign inst_valid = (w_count != '0);
    assign inst       = w_head_entry.inst;
    assign inst_pc    = w_head_entry.pc;

    // Redirect PC low bits are ignored; the empty flag duplicates inst_valid.
    assign w_unused = ^{redirect_pc[1:0], w_empty};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc  <= RESET_PC;
            r_bcnt <= 2'd0;
            r_asm  <= 24'd0;
        end else if (redirect) begin
            r_fpc  <= {redirect_pc[31:2], 2'b00};
            r_bcnt <= 2'd0;
        end else if (!w_word_done) begin
            // Shift in big-endian order: byte 0 ends up in r_asm[23:16].
            r_asm  <= {r_asm[15:0], imem_data};
            r_bcnt <= r_bcnt + 2'd1;
        end else if (w_push_ok) begin
            r_fpc  <= r_fpc + PC_W'(4);
            r_bcnt <= 2'd0;
        end
        // Otherwise hold: byte 3 is re-sampled every cycle until the push.
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a scoreboard of expected (pc, inst) pops.
// Latency: n/a.  Backpressure: inst_ready driven by the directed sequence.
module tb_fetch_prefetch;
    import cpu_pkg::*;

    localparam int ADDR_W = 5;
    localparam int MEM_SZ = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              inst_ready;

    logic [7:0]   mem [MEM_SZ];
    fetch_entry_t sb [$];
    int           n_checks;
    int           n_errors;

    fetch_prefetch #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    assign imem_data = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [ADDR_W-1:0] a;
        a = pc[ADDR_W-1:0];
        return {mem[a], mem[a + 5'd1], mem[a + 5'd2], mem[a + 5'd3]};
    endfunction

    task automatic expect_pop(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = exp_word(pc);
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every accepted instruction is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            fetch_entry_t e;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL pop_unexpected: got pc %h with empty scoreboard", inst_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_inst", inst, e.inst);
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b1;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20; mem[1] = 8'h04; mem[2] = 8'h00; mem[3] = 8'h05;

        // ---- reset state ----
        #1;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        step(2);
        rst_n = 1'b1;

        // ---- first word, consumer ready ----
        expect_pop(32'h0);
        expect_pop(32'h4);
        step(1);
        chk("w0_addr1", 32'(imem_addr), 32'd1);
        step(2);
        chk("w0_valid_e3", 32'(inst_valid), 32'd0);
        chk("w0_addr3", 32'(imem_addr), 32'd3);
        step(1);
        chk("w0_valid_e4", 32'(inst_valid), 32'd1);
        chk("w0_inst", inst, 32'h20040005);
        chk("w0_pc", inst_pc, 32'h0);
        step(1);
        chk("w0_popped", 32'(inst_valid), 32'd0);
        step(3);
        chk("w1_valid_e8", 32'(inst_valid), 32'd1);
        chk("w1_pc", inst_pc, 32'h4);
        inst_ready = 1'b0;

        // ---- async reset with 3 queued, bcnt=1 ----
        step(9);
        chk("pre_rst_count", 32'(dut.w_count), 32'd3);
        chk("pre_rst_bcnt", 32'(dut.r_bcnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_inst", inst, 32'd0);
        chk("arst_pc", inst_pc, 32'd0);
        sb.delete();
        step(2);
        rst_n = 1'b1;

        // ---- restart with consumer stalled: backpressure fill ----
        step(3);
        chk("r_valid_e3", 32'(inst_valid), 32'd0);
        step(1);
        chk("r_valid_e4", 32'(inst_valid), 32'd1);
        chk("r_inst", inst, 32'h20040005);
        chk("r_pc", inst_pc, 32'h0);
        step(36);
        chk("fill_count", 32'(dut.w_count), 32'd4);
        chk("fill_addr", 32'(imem_addr), 32'd19);
        chk("fill_bcnt", 32'(dut.r_bcnt), 32'd3);
        chk("fill_head_pc", inst_pc, 32'h0);
        for (int pc = 0; pc <= 16; pc += 4) expect_pop(32'(pc));

        // ---- full: single-cycle pop with simultaneous push ----
        inst_ready = 1'b1;
        step(1);
        inst_ready = 1'b0;
        chk("pp_count", 32'(dut.w_count), 32'd4);
        chk("pp_head_pc", inst_pc, 32'h4);
        chk("pp_addr", 32'(imem_addr), 32'd20);

        // ---- drain the rest in order ----
        inst_ready = 1'b1;
        step(4);
        inst_ready = 1'b0;
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_count", 32'(dut.w_count), 32'd1);
        chk("drain_head_pc", inst_pc, 32'd20);

        // ---- redirect mid-word with 2 queued ----
        step(6);
        chk("redir_pre_count", 32'(dut.w_count), 32'd2);
        chk("redir_pre_bcnt", 32'(dut.r_bcnt), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000000E;
        step(1);
        redirect = 1'b0;
        sb.delete();
        chk("redir_valid", 32'(inst_valid), 32'd0);
        chk("redir_addr12", 32'(imem_addr), 32'd12);
        step(1);
        chk("redir_addr13", 32'(imem_addr), 32'd13);
        step(2);
        chk("redir_addr15", 32'(imem_addr), 32'd15);
        chk("redir_valid_e3", 32'(inst_valid), 32'd0);
        step(1);
        chk("redir_valid_e4", 32'(inst_valid), 32'd1);
        chk("redir_pc", inst_pc, 32'd12);
        chk("redir_inst", inst, exp_word(32'd12));
        expect_pop(32'd12);
        inst_ready = 1'b1;
        step(1);
        inst_ready = 1'b0;
        chk("redir_sb_empty", 32'(sb.size()), 32'd0);
        chk("redir_drained", 32'(inst_valid), 32'd0);

        // ---- address wrap ----
        redirect    = 1'b1;
        redirect_pc = 32'h0000001C;
        step(1);
        redirect = 1'b0;
        chk("wrap_addr28", 32'(imem_addr), 32'd28);
        step(4);
        chk("wrap_w0_pc", inst_pc, 32'h1C);
        chk("wrap_addr0", 32'(imem_addr), 32'd0);
        step(1);
        chk("wrap_addr1", 32'(imem_addr), 32'd1);
        step(2);
        chk("wrap_addr3", 32'(imem_addr), 32'd3);
        step(1);
        chk("wrap_count", 32'(dut.w_count), 32'd2);
        chk("wrap_addr4", 32'(imem_addr), 32'd4);
        expect_pop(32'h1C);
        expect_pop(32'h20);
        inst_ready = 1'b1;
        step(2);
        inst_ready = 1'b0;
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Instruction fetch stage upstream of the single-cycle processor datapath. It reads the byte-wide, big-endian instruction memory one byte per cycle and assembles 32-bit instruction words. It buffers those words with their PCs in a small prefetch queue and hands them to decode over a valid/ready handshake. A synchronous redirect (taken branch) flushes the queue and restarts fetch at a new PC.

## Interface
- `ADDR_W`, 5, instruction memory byte-address width; memory is 2^ADDR_W bytes.
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0, fetch PC after reset; bits [1:0] must be 0.
- `clk  in  1  clock; all state updates on rising edge`
- `rst_n  in  1  reset, asynchronous, active-low`
- `imem_addr  out  ADDR_W  byte address into instruction memory`
- `imem_data  in  8  byte at imem_addr, combinational (same-cycle) read`
- `redirect  in  1  flush queue and restart fetch this edge`
- `redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 00)`
- `inst_valid  out  1  queue head holds a valid instruction`
- `inst  out  32  head instruction word`
- `inst_pc  out  32  byte PC of head instruction`
- `inst_ready  in  1  consumer accepts head this cycle`

## Operation
- State: fetch PC `fpc` (32 b), byte index `bcnt` (2 b), assembly register `asm` (24 b), and queue storage, pointers and `count`.
- `imem_addr = fpc[ADDR_W-1:0] + bcnt`, truncated to ADDR_W. Addresses wrap modulo 2^ADDR_W. `fpc` itself is never truncated.
- Byte order: `bcnt`=0 → `inst[31:24]`, 1 → `[23:16]`, 2 → `[15:8]`, 3 → `[7:0]`.
- For `bcnt` 0–2: latch `imem_data` into `asm` and increment `bcnt`. This step never stalls.
- For `bcnt`==3: if push is allowed, write `{asm, imem_data}` and `fpc` into the queue tail, set `fpc += 4` and `bcnt = 0`. Otherwise hold all fetch state.
- Push is allowed when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
- Pop occurs when `inst_valid && inst_ready`. The head advances and `count` decrements, unless a push happens in the same cycle, in which case `count` is unchanged.
- `inst_valid = (count != 0)`. `inst` and `inst_pc` come combinationally from the head entry. Their value while `inst_valid`=0 is don't-care.
- Redirect has highest priority. On that edge:
  - `count`, head and tail are cleared to 0, and `bcnt` is cleared to 0.
  - `fpc` is set to `{redirect_pc[31:2], 2'b00}`.
  - Any push in that cycle is discarded.
  - A pop in the redirect cycle counts as consumed; the consumer owns that instruction.
- `rst_n` low at any time, including mid-word or while the queue is full, takes effect asynchronously:
  - `fpc`=RESET_PC, `bcnt`=0, `asm`=0, `count`=0, pointers=0, storage cleared to 0.
  - Resulting outputs: `inst_valid`=0, `inst`=0, `inst_pc`=0, `imem_addr`=RESET_PC[ADDR_W-1:0].

## Timing
- After reset release, the bytes of word 0 are read on cycles 0–3. The push happens on edge 4, and `inst_valid` is high after edge 4.
- Steady-state throughput is 1 instruction per 4 cycles. Byte fetch continues while the consumer stalls, until the queue is full and `bcnt`==3.
- Latency from redirect edge to `inst_valid`: 4 cycles. There is no stale-instruction bubble: valid is low on the cycle after the redirect.
- When full with `inst_ready`=0, `imem_addr` stays at the word's byte 3 address and the byte is re-sampled on every cycle until the push.
- No combinational path from `inst_ready` or `redirect` to `imem_addr`. `inst_ready` reaches only the pop/push enables.

## Structure
- Shared package `cpu_pkg` holds:
  - `INST_W`=32 and `PC_W`=32.
  - The default `ADDR_W`.
  - Typedef `fetch_entry_t` = {pc[31:0], inst[31:0]}.
- One sub-module: `sync_fifo`, parameterized width and depth. It provides push/pop, flush, `count`, and a full/empty flag. The fetch unit instantiates it with `fetch_entry_t` width and `DEPTH`.
- Top-level logic: fetch PC/byte counter, assembly register, push-allowed and redirect control.

## Test plan
- **Reset and first word:** memory bytes 0–3 = 20 04 00 05, `inst_ready`=1. Required: `inst_valid` rises after edge 4 with `inst`=32'h20040005 and `inst_pc`=0; next word has `inst_pc`=4 after edge 8.
- **Backpressure fill:** `inst_ready`=0 for 40 cycles. Required:
  - `count` saturates at 4 with PCs 0, 4, 8, 12.
  - `imem_addr` holds at 19.
  - Raising `inst_ready` pops PCs 0, 4, 8, 12, 16 in order with no loss or duplication.
- **Full with simultaneous pop/push:** queue full, `bcnt`==3, `inst_ready`=1 for one cycle. Required: head advances, the new word is pushed, and `count` stays 4.
- **Redirect mid-word:** `bcnt`=2 with 2 entries queued; pulse `redirect` with `redirect_pc`=32'h0000000E. Required:
  - `inst_valid`=0 on the next cycle.
  - Fetch restarts at address 12, reading bytes 12–15.
  - First valid has `inst_pc`=12, 4 cycles later.
- **Address wrap:** redirect to 32'h0000001C, then let two words fetch. Required:
  - The second word reads addresses 0–3.
  - Its `inst_pc`=32'h00000020, not truncated.
- **Async reset mid-operation:** assert `rst_n`=0 between edges with 3 entries queued and `bcnt`=1. Required: `inst_valid`=0 and `imem_addr`=0 immediately, before the next edge; after release, behaviour matches the reset and first-word scenario.
